// File: rtl/fifo_sync_reg_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sync_reg_pkg
// Shared constants and helpers for the datapath buffers.
//   DEFAULT_DATA_WIDTH : default stored word width
//   DEFAULT_ADDR_WIDTH : default log2 of buffer depth
//   clog2()            : ceiling log2, usable in constant expressions
// -----------------------------------------------------------------------------
package fifo_sync_reg_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  // Smallest r with 2**r >= value; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ram_sdp_sync.sv
// -----------------------------------------------------------------------------
// ram_sdp_sync
// Simple dual-port storage array: one write port, one registered read port.
// Ports:
//   clk      : clock, all updates on rising edge
//   reset    : synchronous active-high, clears only the read register
//   wr_en    : write strobe, wr_data stored at wr_addr
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe, rd_data loads mem[rd_addr] on the next edge
//   rd_addr  : read address
//   rd_data  : registered read data, holds when rd_en is low
// -----------------------------------------------------------------------------
module ram_sdp_sync
  import fifo_sync_reg_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  // NOTE: the array has no reset so it maps onto RAM primitives; stale words are
  // never observable because the owner's pointers and count are reset instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_sync_reg.sv
// -----------------------------------------------------------------------------
// fifo_sync_reg
// Single-clock FIFO between a push-strobed producer and a pop-strobed consumer.
// Read data is registered and qualified by data_out_valid one cycle after pop.
// Ports:
//   clk            : clock
//   reset          : synchronous active-high reset, priority over all inputs
//   push, data_in  : write strobe and data; accepted when not full
//   pop            : read strobe; accepted when not empty
//   data_out       : registered read data, holds when no pop is accepted
//   data_out_valid : high for one cycle after each accepted pop
//   full, empty    : count == DEPTH, count == 0
//   almost_full    : count >= ALMOST_FULL_LEVEL
//   count          : stored words, 0..DEPTH
//   overflow       : sticky, push seen while full
//   underflow      : sticky, pop seen while empty
// -----------------------------------------------------------------------------
module fifo_sync_reg
  import fifo_sync_reg_pkg::*;
#(
  parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH        = DEFAULT_ADDR_WIDTH,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH       = 1 << ADDR_WIDTH;
  // Count needs one more bit than the pointers to tell full from empty.
  localparam int COUNT_WIDTH = clog2(DEPTH + 1);

  localparam logic [COUNT_WIDTH-1:0] DEPTH_COUNT = COUNT_WIDTH'(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] AF_COUNT    = COUNT_WIDTH'(ALMOST_FULL_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // Flags decode the registered count, so they only move on clock edges.
  assign full        = (count == DEPTH_COUNT);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_COUNT);

  // Acceptance looks only at the current state, never at the opposite strobe:
  // push while full is refused even with a pop, pop while empty even with a push.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // When both are accepted count >= 1 and < DEPTH, so rd_ptr != wr_ptr and the
  // read returns the old head while the write lands at the tail.
  ram_sdp_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_ok & ~reset),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

  // NOTE: state registers use non-blocking assignments so every read in this
  // block sees the pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      data_out_valid <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;  // wraps modulo DEPTH
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;

      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      data_out_valid <= pop_ok;

      if (push && full)  overflow  <= 1'b1;
      if (pop && empty)  underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_sync_reg.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_reg
// Directed self-checking bench for fifo_sync_reg (default 8-bit x 16 entries,
// almost_full at 12). Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_sync_reg;

  logic       clk;
  logic       reset;
  logic       push;
  logic [7:0] data_in;
  logic       pop;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int passed = 0;

  fifo_sync_reg dut (
    .clk            (clk),
    .reset          (reset),
    .push           (push),
    .data_in        (data_in),
    .pop            (pop),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .full           (full),
    .empty          (empty),
    .almost_full    (almost_full),
    .count          (count),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // One clock with the given strobes; outputs settle by the time it returns.
  task automatic cycle(input logic p, input logic [7:0] d, input logic q);
    push    = p;
    data_in = d;
    pop     = q;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  logic [7:0] sb[$];
  logic [7:0] exp_word;
  int         sent;
  int         got;
  bit         p_r;
  bit         q_r;
  bit         pend;

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;

    // Reset then idle
    cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 0);
    reset = 1'b0;
    cycle(0, 8'h00, 0);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_dout", 32'(data_out), 0);
    check("rst_valid", 32'(data_out_valid), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);

    // Three pushes then three pops
    cycle(1, 8'h11, 0);
    cycle(1, 8'h22, 0);
    cycle(1, 8'h33, 0);
    check("fill3_count", 32'(count), 3);
    check("fill3_empty", 32'(empty), 0);
    cycle(0, 8'h00, 1);
    check("pop1_dout", 32'(data_out), 32'h11);
    check("pop1_valid", 32'(data_out_valid), 1);
    check("pop1_count", 32'(count), 2);
    cycle(0, 8'h00, 1);
    check("pop2_dout", 32'(data_out), 32'h22);
    check("pop2_count", 32'(count), 1);
    cycle(0, 8'h00, 1);
    check("pop3_dout", 32'(data_out), 32'h33);
    check("pop3_valid", 32'(data_out_valid), 1);
    check("pop3_empty", 32'(empty), 1);
    cycle(0, 8'h00, 0);
    check("idle_valid", 32'(data_out_valid), 0);
    check("idle_dout_hold", 32'(data_out), 32'h33);

    // Fill to 16, overflow attempt, drain
    for (int i = 0; i < 16; i++) begin
      cycle(1, 8'(i), 0);
      if (i == 10) check("afull_at11", 32'(almost_full), 0);
      if (i == 11) check("afull_at12", 32'(almost_full), 1);
      if (i == 14) check("full_at15", 32'(full), 0);
    end
    check("fill16_count", 32'(count), 16);
    check("fill16_full", 32'(full), 1);
    check("pre_ovf", 32'(overflow), 0);
    cycle(1, 8'hAA, 0);
    check("ovf_count", 32'(count), 16);
    check("ovf_flag", 32'(overflow), 1);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 8'h00, 1);
      check("drain_dout", 32'(data_out), 32'(i));
      check("drain_valid", 32'(data_out_valid), 1);
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_afull", 32'(almost_full), 0);

    // Pop on empty, then push+pop on empty
    cycle(0, 8'h00, 1);
    check("unf_flag", 32'(underflow), 1);
    check("unf_valid", 32'(data_out_valid), 0);
    check("unf_dout", 32'(data_out), 32'h0F);
    check("unf_count", 32'(count), 0);
    cycle(1, 8'h5A, 1);
    check("pp_empty_count", 32'(count), 1);
    check("pp_empty_valid", 32'(data_out_valid), 0);

    // Simultaneous push+pop at count 1 (head 0x5A)
    cycle(1, 8'h6B, 1);
    check("pp1_dout", 32'(data_out), 32'h5A);
    check("pp1_valid", 32'(data_out_valid), 1);
    check("pp1_count", 32'(count), 1);
    cycle(0, 8'h00, 1);
    check("pp1_next_dout", 32'(data_out), 32'h6B);
    check("pp1_next_count", 32'(count), 0);

    // Random stream of 40 words across pointer wrap, against a scoreboard
    sent = 0; got = 0; pend = 0;
    sb.delete();
    for (int c = 0; c < 2000 && got < 40; c++) begin
      p_r = (sent < 40) && ($urandom_range(0, 3) != 0);
      q_r = ($urandom_range(0, 2) != 0);
      // The model decides acceptance from its own occupancy before the edge.
      pend = 0;
      if (q_r && sb.size() > 0) begin
        exp_word = sb.pop_front();
        pend = 1;
      end
      if (p_r && (sb.size() + (pend ? 1 : 0)) < 16) begin
        sb.push_back(8'(8'h80 + sent));
        sent++;
      end else begin
        p_r = 0;
      end
      cycle(p_r, 8'(8'h80 + sent - (p_r ? 1 : 0)), q_r);
      if (pend) begin
        got++;
        check("stream_dout", 32'(data_out), 32'(exp_word));
      end
      check("stream_valid", 32'(data_out_valid), 32'(pend));
      check("stream_count", 32'(count), 32'(sb.size()));
    end
    check("stream_done", 32'(got), 40);

    // Mid-operation reset with 7 words stored
    for (int i = 0; i < 7; i++) cycle(1, 8'(8'h40 + i), 0);
    check("pre_rst_count", 32'(count), 7);
    check("sticky_ovf", 32'(overflow), 1);
    check("sticky_unf", 32'(underflow), 1);
    reset = 1'b1;
    cycle(1, 8'hEE, 1);
    reset = 1'b0;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_ovf", 32'(overflow), 0);
    check("mid_rst_unf", 32'(underflow), 0);
    check("mid_rst_dout", 32'(data_out), 0);
    cycle(1, 8'hC3, 0);
    check("post_rst_count", 32'(count), 1);
    cycle(0, 8'h00, 1);
    check("post_rst_dout", 32'(data_out), 32'hC3);
    check("post_rst_valid", 32'(data_out_valid), 1);
    check("post_rst_empty", 32'(empty), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_reg.md
Name: fifo_sync_reg

Overview:
- Synchronous single-clock FIFO that buffers words produced by the enable-gated register stage of the datapath and releases them to the consumer on demand.
- Decouples a producer that writes with a push strobe from a consumer that reads with a pop strobe.
- Read data is registered, so the consumer sees a clean register output with a valid qualifier.
- Provides full/empty/almost_full status and sticky overflow/underflow error flags for debug.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 16 entries).
- ALMOST_FULL_LEVEL, 12, count at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write strobe; data_in is written when accepted.
- data_in  input  DATA_WIDTH  write data.
- pop  input  1  read strobe.
- data_out  output  DATA_WIDTH  registered read data.
- data_out_valid  output  1  high for exactly one cycle after each accepted pop.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= ALMOST_FULL_LEVEL.
- count  output  ADDR_WIDTH+1  number of stored words, 0..DEPTH.
- overflow  output  1  sticky; set by a push while full.
- underflow  output  1  sticky; set by a pop while empty.

Behaviour:
- Reset (synchronous, active-high) has priority over all other inputs in the same cycle.
  - Clears wr_ptr, rd_ptr, count, data_out, data_out_valid, overflow and underflow.
  - Outputs after reset: empty=1, full=0, almost_full=0.
  - Storage array contents are not reset.
- Reset asserted mid-operation discards all stored words. The next cycle behaves as a fresh FIFO.
- Push acceptance: push_ok = push & ~full. Acceptance ignores pop, so a push while full is rejected even if a pop occurs in the same cycle.
- Pop acceptance: pop_ok = pop & ~empty. Acceptance ignores push, so a pop while empty is rejected even if a push occurs in the same cycle.
- On push_ok: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- On pop_ok: data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1, wrapping; data_out_valid <= 1.
- Pop latency: data appears one cycle after the accepted pop.
- When there is no accepted pop: data_out_valid <= 0 and data_out holds its previous value.
- Count update:
  - +1 on push_ok only.
  - -1 on pop_ok only.
  - Unchanged when both or neither are accepted.
- Simultaneous push_ok and pop_ok, including at count==1:
  - The read returns the old head word.
  - The write lands at the tail.
  - No read-during-write hazard arises because rd_ptr != wr_ptr whenever both are accepted.
- Flags full, empty and almost_full are combinational decodes of the registered count. They are therefore glitch-free and change only on clock edges.
- Error flags:
  - overflow <= 1 on push & full.
  - underflow <= 1 on pop & empty.
  - Both remain set until reset.
  - Rejected operations change no pointer, count or data_out.
- Pointers are ADDR_WIDTH bits wide; count is kept separately at ADDR_WIDTH+1 bits to disambiguate full from empty.

Decomposition:
- Shared package/header: the clog2 helper function and the default DATA_WIDTH/ADDR_WIDTH constants used across datapath buffers.
- One sub-module, ram_sdp_sync:
  - simple dual-port array with one write port and one registered read port;
  - parameterized on DATA_WIDTH and ADDR_WIDTH;
  - no reset on its contents.
- Pointer, count and flag logic stay in the top module.

Test Plan:
- Reset then idle: count=0, empty=1, full=0, data_out=0, data_out_valid=0, overflow=0, underflow=0.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop three times:
  - data_out = 0x11, 0x22, 0x33 with data_out_valid high on the cycle after each pop;
  - count steps 3→0; empty reasserts.
- Fill 16 words (0x00..0x0F):
  - almost_full rises when count reaches 12; full=1 at 16;
  - push of 0xAA while full: count stays 16, overflow=1;
  - drain returns 0x00..0x0F, never 0xAA.
- Pop on empty FIFO: underflow=1, data_out_valid=0, data_out unchanged, count stays 0. A simultaneous push+pop on empty accepts only the push (count=1).
- With count=1 (head 0x5A), push 0x6B and pop in the same cycle: data_out=0x5A next cycle, count stays 1, the following pop returns 0x6B.
- Wrap-around and mid-operation reset:
  - 40 words streamed with random push/pop keep order versus a scoreboard across pointer wrap;
  - reset asserted with count=7 gives count=0 and empty=1 on the next cycle, and the first subsequent push/pop returns the new word.
